instruction_loader: RTL and testbench
=====================================

INSTRUCTION_LOADER -- requirements
Module: instruction_loader

Interface
REQ-001 SHALL have parameter MAX_WORDS, default 1024, meaning the largest accepted program length in words.
REQ-002 SHALL have parameter BASE_ADDR, default 0, meaning the byte address of the first instruction word.
REQ-003 SHALL have port clock  input  1  the single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port start  input  1  single-cycle request to begin a load.
REQ-006 SHALL have port byte_valid  input  1  byte_data holds a valid byte.
REQ-007 SHALL have port byte_data  input  8  incoming program byte.
REQ-008 SHALL have port byte_ready  output  1  loader accepts a byte this cycle.
REQ-009 SHALL have port mem_write  output  1  write request to instruction memory.
REQ-010 SHALL have port mem_addr  output  word_address  byte address of the word being written.
REQ-011 SHALL have port mem_data  output  word  assembled instruction word.
REQ-012 SHALL have port mem_ready  input  1  memory accepts the write this cycle.
REQ-013 SHALL have port core_reset  output  1  holds the core (program_counter etc.) in reset while high.
REQ-014 SHALL have port done  output  1  load completed successfully.
REQ-015 SHALL have port error  output  1  load rejected due to an illegal length.
REQ-016 SHALL have port words_loaded  output  16  count of words written in the current load.

Function
REQ-017 SHALL implement states IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE, ERROR.
REQ-018 SHALL accept a byte only on a cycle with byte_valid && byte_ready; byte_ready SHALL be 1 only in LEN_LO, LEN_HI and DATA.
REQ-019 SHALL move IDLE, DONE or ERROR -> LEN_LO on start, clearing words_loaded, done and error; start SHALL be ignored in all other states.
REQ-020 SHALL capture the first accepted byte as count N[7:0] (LEN_LO -> LEN_HI) and the second as N[15:8] (LEN_HI -> check).
REQ-021 SHALL go to ERROR if N == 0 or N > MAX_WORDS, otherwise to DATA, in the cycle after the N[15:8] byte is accepted.
REQ-022 SHALL assemble each word little-endian in DATA: the first byte goes to bits 7:0 and the fourth to bits 31:24.
REQ-023 SHALL enter WRITE in the cycle after the fourth byte is accepted, with mem_write=1, mem_data=the assembled word and mem_addr=BASE_ADDR + 4*words_loaded.
REQ-024 SHALL hold mem_write, mem_addr and mem_data stable in WRITE until mem_ready=1; no bytes SHALL be accepted in WRITE.
REQ-025 SHALL, on the mem_ready cycle, increment words_loaded and go to DONE if the new count equals N, else to DATA.
REQ-026 SHALL set core_reset=1 in every state except DONE; core_reset SHALL be 0 only in DONE.
REQ-027 SHALL set done=1 only in DONE and error=1 only in ERROR.
REQ-028 SHALL not wrap mem_addr, because N <= MAX_WORDS bounds the address range.
REQ-029 SHALL retain the partial word when byte_valid drops mid-word, and resume assembly when it returns.

Reset
REQ-030 SHALL, while reset_n=0, immediately force: state IDLE, core_reset=1, mem_write=0, byte_ready=0, done=0, error=0, words_loaded=0, mem_addr=BASE_ADDR, mem_data=0.
REQ-031 SHALL abandon any load in progress on reset assertion, leaving partially written memory unchanged; a new start is required after reset.

Structure
REQ-032 SHALL take the word and word_address typedefs from the shared definitions header; the loader state enum SHALL be added there.
REQ-033 SHALL be a single module; the byte-to-word assembler MAY be a sub-module named byte_word_packer.

Verification
REQ-034 SHALL cover: start, N=2, bytes 13 00 00 00 93 00 10 00 -> writes 0x00000013 at BASE_ADDR and 0x00100093 at BASE_ADDR+4; done=1; core_reset=0.
REQ-035 SHALL cover: N=0 and, separately, N=MAX_WORDS+1 -> error=1, no mem_write, core_reset=1.
REQ-036 SHALL cover: mem_ready held 0 for 5 cycles in WRITE -> outputs stable, byte_ready=0, exactly one write counted.
REQ-037 SHALL cover: byte_valid gaps inside a word -> same assembled word as the gap-free case.
REQ-038 SHALL cover: reset_n pulsed low after 3 of 8 data bytes -> state IDLE, core_reset=1, words_loaded=0; a new full load then succeeds.
REQ-039 SHALL cover: start asserted in DATA -> ignored; start in DONE -> new load begins and core_reset returns to 1.

Source files
------------

// File: rtl/instruction_loader_pkg.sv
// Shared types for the instruction loader: word/address typedefs and the loader state encoding.
package instruction_loader_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned COUNT_W = 16;

  typedef logic [WORD_W-1:0] word;
  typedef logic [ADDR_W-1:0] word_address;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    WRITE,
    DONE,
    ERROR
  } loader_state_e;

  // Byte address of word number idx in a program placed at base.
  function automatic word_address word_addr(input word_address base, input logic [COUNT_W-1:0] idx);
    return base + (ADDR_W'(idx) << 2);
  endfunction

endpackage

// File: rtl/byte_word_packer.sv
// Little-endian byte-to-word assembler; the partial word survives gaps in the byte stream.
module byte_word_packer
  import instruction_loader_pkg::*;
(
  input  logic                clock,
  input  logic                reset_n,
  input  logic                clear,
  input  logic                byte_en,
  input  logic [BYTE_W-1:0]   byte_data,
  output logic [WORD_W-1:0]   word_c,
  output logic                complete_c
);

  logic [1:0]  idx;
  logic [23:0] partial;

  // The fourth byte completes the word combinationally so the loader can latch it on acceptance.
  always_comb begin
    word_c     = {byte_data, partial};
    complete_c = byte_en && (idx == 2'd3);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      idx     <= 2'd0;
      partial <= 24'd0;
    end else if (clear) begin
      idx     <= 2'd0;
      partial <= 24'd0;
    end else if (byte_en) begin
      case (idx)
        2'd0:    partial[7:0]   <= byte_data;
        2'd1:    partial[15:8]  <= byte_data;
        2'd2:    partial[23:16] <= byte_data;
        default: partial        <= partial;
      endcase
      idx <= idx + 2'd1;
    end
  end

endmodule

// File: rtl/instruction_loader.sv
// Loads a length-prefixed byte stream into instruction memory as 32-bit words,
// holding the core in reset until the whole program has been written.
module instruction_loader
  import instruction_loader_pkg::*;
#(
  parameter int unsigned MAX_WORDS = 1024,
  parameter word_address BASE_ADDR = '0
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                start,
  input  logic                byte_valid,
  input  logic [BYTE_W-1:0]   byte_data,
  output logic                byte_ready,
  output logic                mem_write,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [WORD_W-1:0]   mem_data,
  input  logic                mem_ready,
  output logic                core_reset,
  output logic                done,
  output logic                error,
  output logic [COUNT_W-1:0]  words_loaded
);

  loader_state_e state, next_state;

  logic                byte_ready_d, mem_write_d, core_reset_d, done_d, error_d;
  logic [BYTE_W-1:0]   len_lo;
  logic [COUNT_W-1:0]  len;
  logic [COUNT_W-1:0]  len_c;
  logic                accept_c, restart_c, len_bad_c, last_word_c;
  logic                pack_en_c, word_complete_c;
  word                 packed_word_c;

  always_comb begin
    accept_c    = byte_valid && byte_ready;
    restart_c   = start && (state == IDLE || state == DONE || state == ERROR);
    len_c       = {byte_data, len_lo};
    len_bad_c   = (len_c == '0) || (32'(len_c) > MAX_WORDS);
    last_word_c = (words_loaded + 16'd1) == len;
    pack_en_c   = (state == DATA) && accept_c;
  end

  byte_word_packer u_packer (
    .clock      (clock),
    .reset_n    (reset_n),
    .clear      (restart_c),
    .byte_en    (pack_en_c),
    .byte_data  (byte_data),
    .word_c     (packed_word_c),
    .complete_c (word_complete_c)
  );

  // State register; control outputs are registered decodes of the next state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      byte_ready <= 1'b0;
      mem_write  <= 1'b0;
      core_reset <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      state      <= next_state;
      byte_ready <= byte_ready_d;
      mem_write  <= mem_write_d;
      core_reset <= core_reset_d;
      done       <= done_d;
      error      <= error_d;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE, ERROR: if (start) next_state = LEN_LO;
      LEN_LO:            if (accept_c) next_state = LEN_HI;
      LEN_HI:            if (accept_c) next_state = len_bad_c ? ERROR : DATA;
      DATA:              if (word_complete_c) next_state = WRITE;
      WRITE:             if (mem_ready) next_state = last_word_c ? DONE : DATA;
      default:           next_state = IDLE;
    endcase
  end

  always_comb begin
    byte_ready_d = 1'b0;
    mem_write_d  = 1'b0;
    core_reset_d = 1'b1;
    done_d       = 1'b0;
    error_d      = 1'b0;
    case (next_state)
      LEN_LO, LEN_HI, DATA: byte_ready_d = 1'b1;
      WRITE:                mem_write_d  = 1'b1;
      DONE: begin
        core_reset_d = 1'b0;
        done_d       = 1'b1;
      end
      ERROR:                error_d      = 1'b1;
      default:              ;
    endcase
  end

  // Length capture, write payload and word counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      len_lo       <= '0;
      len          <= '0;
      words_loaded <= '0;
      mem_addr     <= BASE_ADDR;
      mem_data     <= '0;
    end else begin
      if (restart_c) words_loaded <= '0;
      if (state == LEN_LO && accept_c) len_lo <= byte_data;
      if (state == LEN_HI && accept_c) len <= len_c;
      if (word_complete_c) begin
        mem_data <= packed_word_c;
        mem_addr <= word_addr(BASE_ADDR, words_loaded);
      end
      if (state == WRITE && mem_ready) words_loaded <= words_loaded + 16'd1;
    end
  end

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader; a negedge monitor checks every memory write against a queue.
module tb_instruction_loader;
  import instruction_loader_pkg::*;

  localparam int unsigned MAXW = 4;
  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        mem_ready = 1'b1;
  logic        byte_ready, mem_write, core_reset, done, error;
  logic [31:0] mem_addr, mem_data;
  logic [15:0] words_loaded;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] prog [4];
  int          checks = 0;
  int          errors = 0;
  int          writes = 0;
  int          w0;

  instruction_loader #(.MAX_WORDS(MAXW), .BASE_ADDR(BASE)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .start        (start),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .byte_ready   (byte_ready),
    .mem_write    (mem_write),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .mem_ready    (mem_ready),
    .core_reset   (core_reset),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every accepted write must match the oldest expected write.
  always @(negedge clock) begin : mon
    wr_t e;
    if (reset_n && mem_write && mem_ready) begin
      writes++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: write addr 0x%08h data 0x%08h, none expected", mem_addr, mem_data);
      end else begin
        e = exp_q.pop_front();
        check("sb_addr", mem_addr, e.addr);
        check("sb_data", mem_data, e.data);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && n < 200) begin
      step();
      n++;
    end
    if (!byte_ready) begin
      checks++;
      errors++;
      $display("FAIL send_byte: byte_ready stayed 0, required 1 within 200 cycles");
    end else begin
      step();
    end
    byte_valid = 1'b0;
  endtask

  task automatic wait_end(input string name);
    int n = 0;
    while (!(done || error) && n < 300) begin
      step();
      n++;
    end
    if (!(done || error)) begin
      checks++;
      errors++;
      $display("FAIL %s: done/error still 0, required 1 within 300 cycles", name);
    end
  endtask

  task automatic send_program(input int n, input int gap, input bit start_mid);
    logic [15:0] nn;
    nn = 16'(n);
    for (int i = 0; i < n; i++) exp_q.push_back({BASE + 32'(i * 4), prog[i]});
    pulse_start();
    send_byte(nn[7:0]);
    send_byte(nn[15:8]);
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 4; k++) begin
        send_byte(prog[i][8*k +: 8]);
        repeat (gap) step();
        if (start_mid && i == 0 && k == 1) pulse_start();
      end
    end
  endtask

  initial begin
    prog[0] = 32'h0000_0013;
    prog[1] = 32'h0010_0093;
    #2 reset_n = 1'b0;
    repeat (3) step();
    check("rst_core_reset", 32'(core_reset), 32'd1);
    check("rst_mem_write", 32'(mem_write), 32'd0);
    check("rst_byte_ready", 32'(byte_ready), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_words", 32'(words_loaded), 32'd0);
    check("rst_addr", mem_addr, BASE);
    check("rst_data", mem_data, 32'd0);
    reset_n = 1'b1;
    step();

    // Two-word program, no gaps.
    w0 = writes;
    send_program(2, 0, 1'b0);
    wait_end("A_wait");
    check("A_done", 32'(done), 32'd1);
    check("A_core_reset", 32'(core_reset), 32'd0);
    check("A_words", 32'(words_loaded), 32'd2);
    check("A_writes", 32'(writes - w0), 32'd2);

    // Restart from DONE, then same program with gaps and a stray start in DATA.
    pulse_start();
    check("B_restart_core_reset", 32'(core_reset), 32'd1);
    check("B_restart_done", 32'(done), 32'd0);
    check("B_restart_words", 32'(words_loaded), 32'd0);
    w0 = writes;
    send_program(2, 2, 1'b1);
    wait_end("B_wait");
    check("B_done", 32'(done), 32'd1);
    check("B_words", 32'(words_loaded), 32'd2);
    check("B_writes", 32'(writes - w0), 32'd2);

    // Zero length is rejected.
    w0 = writes;
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h00);
    wait_end("N0_wait");
    check("N0_error", 32'(error), 32'd1);
    check("N0_done", 32'(done), 32'd0);
    check("N0_core_reset", 32'(core_reset), 32'd1);
    check("N0_byte_ready", 32'(byte_ready), 32'd0);
    check("N0_writes", 32'(writes - w0), 32'd0);

    // One word beyond the limit is rejected.
    pulse_start();
    check("Nmax1_error_cleared", 32'(error), 32'd0);
    send_byte(8'(MAXW + 1));
    send_byte(8'h00);
    wait_end("Nmax1_wait");
    check("Nmax1_error", 32'(error), 32'd1);
    check("Nmax1_core_reset", 32'(core_reset), 32'd1);
    check("Nmax1_writes", 32'(writes - w0), 32'd0);

    // Exactly the limit is accepted.
    prog[2] = 32'hCAFE_F00D;
    prog[3] = 32'h8765_4321;
    w0 = writes;
    send_program(int'(MAXW), 0, 1'b0);
    wait_end("Nmax_wait");
    check("Nmax_done", 32'(done), 32'd1);
    check("Nmax_words", 32'(words_loaded), 32'(MAXW));
    check("Nmax_last_addr", mem_addr, BASE + 32'h0000_000C);

    // Memory stalls for five cycles with bytes offered during the stall.
    prog[0] = 32'hDEAD_BEEF;
    mem_ready = 1'b0;
    w0 = writes;
    send_program(1, 0, 1'b0);
    byte_valid = 1'b1;
    byte_data  = 8'hFF;
    for (int c = 0; c < 5; c++) begin
      check("stall_mem_write", 32'(mem_write), 32'd1);
      check("stall_addr", mem_addr, BASE);
      check("stall_data", mem_data, 32'hDEAD_BEEF);
      check("stall_byte_ready", 32'(byte_ready), 32'd0);
      step();
    end
    byte_valid = 1'b0;
    mem_ready  = 1'b1;
    wait_end("stall_wait");
    check("stall_done", 32'(done), 32'd1);
    check("stall_words", 32'(words_loaded), 32'd1);
    check("stall_writes", 32'(writes - w0), 32'd1);

    // Reset after three of eight data bytes, then a fresh full load.
    prog[0] = 32'h0000_0013;
    w0 = writes;
    pulse_start();
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h13);
    send_byte(8'h00);
    send_byte(8'h00);
    reset_n = 1'b0;
    #1;
    check("mrst_state", 32'(dut.state), 32'(IDLE));
    check("mrst_core_reset", 32'(core_reset), 32'd1);
    check("mrst_words", 32'(words_loaded), 32'd0);
    check("mrst_byte_ready", 32'(byte_ready), 32'd0);
    repeat (2) step();
    reset_n = 1'b1;
    repeat (2) step();
    check("mrst_idle_byte_ready", 32'(byte_ready), 32'd0);
    check("mrst_writes", 32'(writes - w0), 32'd0);
    send_program(2, 1, 1'b0);
    wait_end("mrst_reload_wait");
    check("mrst_reload_done", 32'(done), 32'd1);
    check("mrst_reload_core_reset", 32'(core_reset), 32'd0);
    check("mrst_reload_writes", 32'(writes - w0), 32'd2);

    repeat (2) step();
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
